// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block controller.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    HOLD,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10
  } mode_t;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // One accepted request as presented to the AES core.
  typedef struct packed {
    logic         enc_dec;
    mode_t        mode;
    logic [255:0] key;
    logic [127:0] data;
  } req_t;

endpackage

// File: rtl/aes_block_ctrl_if.sv
// Request/response and core-side signal bundle for aes_block_ctrl.
interface aes_block_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic [1:0]   in_mode;
  logic         in_enc_dec;

  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic         core_start;
  logic         core_enc_dec;
  logic [1:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_data_out;

  logic         err;
  logic         clr_err;

  // Controller side.
  modport slave (
    input  in_valid, in_data, in_key, in_mode, in_enc_dec,
    input  out_ready, core_done, core_data_out, clr_err,
    output in_ready, out_valid, out_data,
    output core_start, core_enc_dec, core_mode, core_key, core_data, err
  );

  // Upstream/downstream/core side.
  modport master (
    output in_valid, in_data, in_key, in_mode, in_enc_dec,
    output out_ready, core_done, core_data_out, clr_err,
    input  in_ready, out_valid, out_data,
    input  core_start, core_enc_dec, core_mode, core_key, core_data, err
  );

endinterface

// File: rtl/aes_block_ctrl.sv
// Sequences one block at a time through an external AES core:
// accept request, pulse core_start, wait for core_done with a timeout,
// then hold the result until downstream takes it.
module aes_block_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  aes_block_ctrl_if.slave bus
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
  // err is raised on the edge where the counter steps onto TIMEOUT-1,
  // which lands exactly TIMEOUT cycles after core_start went high.
  localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT - 2);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  req_t          req;
  logic [127:0]  out_q;
  logic          err_q;

  logic accept, capture, trip, clear;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle strobes; core_done outranks the timeout.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    trip     = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = START;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (bus.core_done) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end else if (cnt == CNT_TRIP) begin
          trip     = 1'b1;
          state_nx = ERR;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      ERR: begin
        if (bus.clr_err) begin
          clear    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Timeout counter: cleared in START, counts WAIT cycles, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == WAIT && !bus.core_done && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Request registers, loaded only on acceptance so they stay stable
  // through START and WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req <= '0;
    end else if (accept) begin
      req <= '{enc_dec: bus.in_enc_dec,
               mode:    mode_t'(bus.in_mode),
               key:     bus.in_key,
               data:    bus.in_data};
    end
  end

  // Result capture, only in the WAIT cycle that sees core_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        out_q <= '0;
    else if (capture) out_q <= bus.core_data_out;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      err_q <= 1'b0;
    else if (trip)  err_q <= 1'b1;
    else if (clear) err_q <= 1'b0;
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.core_start   = (state == START);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_data     = out_q;
  assign bus.err          = err_q;
  assign bus.core_enc_dec = req.enc_dec;
  assign bus.core_mode    = req.mode;
  assign bus.core_key     = req.key;
  assign bus.core_data    = req.data;

endmodule

// File: doc/aes_block_ctrl.md
AES_BLOCK_CTRL -- requirements
Module: aes_block_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles from core_start to core_done before an error is raised.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate the upstream block request is valid.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-006 in_data  input  128  SHALL be the plaintext or ciphertext block.
REQ-007 in_key  input  256  SHALL be the key; for 128/192-bit modes it occupies the upper bits.
REQ-008 in_mode  input  2  SHALL be the key size: 00=128, 01=192, 10=256.
REQ-009 in_enc_dec  input  1  SHALL be the direction: 1=decipher, 0=encipher.
REQ-010 out_valid  output  1  SHALL indicate out_data holds a result.
REQ-011 out_ready  input  1  SHALL indicate downstream accepts out_data.
REQ-012 out_data  output  128  SHALL be the captured core result.
REQ-013 core_start  output  1  SHALL be the single-cycle start pulse to the AES core.
REQ-014 core_enc_dec, core_mode, core_key, core_data  output  1/2/256/128  SHALL be registered copies of the accepted request.
REQ-015 core_done  input  1  SHALL be the AES core completion strobe.
REQ-016 core_data_out  input  128  SHALL be the AES core result, valid in the core_done cycle.
REQ-017 err  output  1  SHALL be a sticky timeout flag.
REQ-018 clr_err  input  1  SHALL clear err and return from ERR to IDLE.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, HOLD and ERR.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: in_valid=1 SHALL latch in_data/in_key/in_mode/in_enc_dec into the core_* registers and go to START.
REQ-022 START SHALL assert core_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 core_* request registers SHALL stay stable from acceptance until the FSM leaves WAIT.
REQ-024 WAIT: core_done=1 SHALL capture core_data_out into out_data and go to HOLD; the capture happens in that same cycle.
REQ-025 WAIT: the counter SHALL increment each cycle without core_done; reaching TIMEOUT-1 with no done SHALL set err and go to ERR.
REQ-026 If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-027 core_done seen outside WAIT SHALL be ignored; out_data SHALL not change.
REQ-028 HOLD SHALL drive out_valid=1 with out_data stable until out_valid&&out_ready, then go to IDLE.
REQ-029 Latency from the in_valid&&in_ready edge to core_start high SHALL be 1 cycle; from the core_done edge to out_valid high SHALL be 1 cycle.
REQ-030 ERR SHALL hold in_ready=0 and out_valid=0 until clr_err=1, then go to IDLE with err=0 on the next cycle.
REQ-031 The counter SHALL be clog2(TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-032 reset SHALL asynchronously force IDLE with core_start=0, out_valid=0, err=0, counter=0, out_data=0, and all core_* registers=0.
REQ-033 reset asserted in WAIT or HOLD SHALL abandon the in-flight block; a later core_done SHALL be ignored per REQ-027.

Structure
REQ-034 The state enum, mode encodings (MODE_128/192/256) and the TIMEOUT default SHALL live in shared package aes_pkg.
REQ-035 No sub-module SHALL be used; the counter and FSM SHALL be inline.

Verification
REQ-036 Encipher: key=000102..0f (mode 00), data=00112233445566778899aabbccddeeff, with aes_core_gen attached -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, core_start pulsed once.
REQ-037 Decipher of that ciphertext with the same key -> out_data=00112233445566778899aabbccddeeff; repeat for mode 10 against the FIPS-197 256-bit vector.
REQ-038 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, no second core_start.
REQ-039 Timeout: stub core never asserts done, TIMEOUT=64 -> err=1 exactly 64 cycles after core_start; clr_err -> IDLE, in_ready=1.
REQ-040 Reset mid-WAIT, then stub asserts core_done -> out_valid stays 0 and in_ready=1 after reset deasserts.
REQ-041 Back-to-back: in_valid held high with out_ready=1 for 3 requests -> exactly 3 core_start pulses and 3 outputs in order.
